collatz_arbiter: RTL and testbench

Shares one Collatz iteration datapath between two requesters, A and B, and sequences it. Each requester has its own soc/eoc handshake, input and result. The datapath computes n/2 for even n and 3n+1 for odd n on a 14-bit accumulator. The block counts iterations until n reaches 1, returns the count k to the requester that owns the datapath, and grants the datapath round-robin when both requesters ask at once.

---
 rtl/collatz_pkg.sv | 20 ++
 rtl/collatz_arbiter_if.sv | 25 ++
 rtl/collatz_step.sv | 16 +
 rtl/collatz_arbiter.sv | 122 ++++++++++++
 tb/tb_collatz_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz arbiter: FSM state encoding,
// datapath owner encoding and default widths.
package collatz_pkg;

    localparam int W_IN  = 8;
    localparam int W_ACC = 14;
    localparam int W_K   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

endpackage

// File: rtl/collatz_arbiter_if.sv
// Two-requester soc/eoc handshake bundle for collatz_arbiter.
// master: requester side (drives soc/n), slave: arbiter side.
interface collatz_arbiter_if #(
    parameter int W_IN = collatz_pkg::W_IN,
    parameter int W_K  = collatz_pkg::W_K
);
    logic            soc_a;
    logic [W_IN-1:0] n_a;
    logic            eoc_a;
    logic [W_K-1:0]  k_a;
    logic            soc_b;
    logic [W_IN-1:0] n_b;
    logic            eoc_b;
    logic [W_K-1:0]  k_b;

    modport master (
        output soc_a, n_a, soc_b, n_b,
        input  eoc_a, k_a, eoc_b, k_b
    );

    modport slave (
        input  soc_a, n_a, soc_b, n_b,
        output eoc_a, k_a, eoc_b, k_b
    );
endinterface

// File: rtl/collatz_step.sv
// One Collatz iteration: n/2 for even n, 3n+1 for odd n, truncated to W_ACC.
module collatz_step #(
    parameter int W_ACC = collatz_pkg::W_ACC
) (
    input  logic [W_ACC-1:0] n_i,
    output logic [W_ACC-1:0] n_o
);
    // Pure combinational step; odd branch wraps modulo 2^W_ACC.
    always_comb begin
        if (n_i[0]) begin
            n_o = (n_i << 1) + n_i + W_ACC'(1);
        end else begin
            n_o = n_i >> 1;
        end
    end
endmodule

// File: rtl/collatz_arbiter.sv
// Round-robin arbiter sharing one Collatz iteration datapath between
// requesters A and B. Counts iterations until n reaches 1 (or 0) and
// returns the count to the owning requester.
// Optional feature macro: COLLATZ_WDOG_EN (step-count watchdog, writes
// all-ones as an error sentinel when K reaches MAX_STEPS).
module collatz_arbiter #(
    parameter int W_IN      = collatz_pkg::W_IN,
    parameter int W_ACC     = collatz_pkg::W_ACC,
    parameter int W_K       = collatz_pkg::W_K,
    parameter int MAX_STEPS = 255
) (
    input logic              clock,
    input logic              reset_,
    collatz_arbiter_if.slave bus
);
    import collatz_pkg::*;

`ifdef COLLATZ_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    state_t             state_q;
    owner_t             owner_q;
    owner_t             pref_q;
    logic [W_ACC-1:0]   n_q;
    logic [W_ACC-1:0]   n_d;
    logic [W_K-1:0]     k_q;
    logic               eoc_a_q;
    logic               eoc_b_q;
    logic [W_K-1:0]     k_a_q;
    logic [W_K-1:0]     k_b_q;
    logic               grant_b;
    logic               owner_soc;
    logic               wdog_hit;

    collatz_step #(.W_ACC(W_ACC)) u_step (
        .n_i (n_q),
        .n_o (n_d)
    );

    // Grant decision, owner's request level and watchdog trip condition.
    always_comb begin
        grant_b   = bus.soc_b && (!bus.soc_a || pref_q == OWNER_B);
        owner_soc = (owner_q == OWNER_B) ? bus.soc_b : bus.soc_a;
        wdog_hit  = WDOG_EN && (k_q == W_K'(MAX_STEPS)) && (n_q != W_ACC'(1));
    end

    // Arbiter FSM, iteration counter and per-requester result registers.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            owner_q <= OWNER_A;
            pref_q  <= OWNER_A;
            n_q     <= '0;
            k_q     <= '0;
            eoc_a_q <= 1'b1;
            eoc_b_q <= 1'b1;
            k_a_q   <= '0;
            k_b_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.soc_a || bus.soc_b) begin
                        k_q     <= '0;
                        state_q <= S_RUN;
                        if (grant_b) begin
                            owner_q <= OWNER_B;
                            n_q     <= W_ACC'(bus.n_b);
                            eoc_b_q <= 1'b0;
                        end else begin
                            owner_q <= OWNER_A;
                            n_q     <= W_ACC'(bus.n_a);
                            eoc_a_q <= 1'b0;
                        end
                        // Pointer only moves on a contested grant.
                        if (bus.soc_a && bus.soc_b) begin
                            pref_q <= grant_b ? OWNER_A : OWNER_B;
                        end
                    end
                end
                S_RUN: begin
                    if (n_q <= W_ACC'(1)) begin
                        state_q <= S_DONE;
                        if (owner_q == OWNER_B) begin
                            k_b_q   <= k_q;
                            eoc_b_q <= 1'b1;
                        end else begin
                            k_a_q   <= k_q;
                            eoc_a_q <= 1'b1;
                        end
                    end else if (wdog_hit) begin
                        state_q <= S_DONE;
                        if (owner_q == OWNER_B) begin
                            k_b_q   <= '1;
                            eoc_b_q <= 1'b1;
                        end else begin
                            k_a_q   <= '1;
                            eoc_a_q <= 1'b1;
                        end
                    end else begin
                        n_q <= n_d;
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!owner_soc) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.eoc_a = eoc_a_q;
    assign bus.eoc_b = eoc_b_q;
    assign bus.k_a   = k_a_q;
    assign bus.k_b   = k_b_q;

endmodule

// File: tb/tb_collatz_arbiter.sv
// Directed testbench for collatz_arbiter with hand-computed stopping times.
module tb_collatz_arbiter;
    import collatz_pkg::*;

    logic clock;
    logic reset_;
    int   checks;
    int   failures;

    collatz_arbiter_if bus ();

    collatz_arbiter #(
        .W_IN      (8),
        .W_ACC     (14),
        .W_K       (8),
        .MAX_STEPS (100)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Clock until the selected side's eoc rises (bounded), checking edge count,
    // that the other side stays idle with an unchanged result, and the peak.
    task automatic await_done(input bit sb, input int exp_edges, input logic [7:0] other_k,
                              input string tag, output int peak);
        int  edges;
        bit  other_ok;
        logic e;
        edges    = 0;
        other_ok = 1'b1;
        peak     = 0;
        e        = 1'b0;
        while (edges < 400 && !e) begin
            if (int'(dut.n_q) > peak) peak = int'(dut.n_q);
            tick();
            edges++;
            e = sb ? bus.eoc_b : bus.eoc_a;
            if (sb) begin
                if (bus.eoc_a !== 1'b1 || bus.k_a !== other_k) other_ok = 1'b0;
            end else begin
                if (bus.eoc_b !== 1'b1 || bus.k_b !== other_k) other_ok = 1'b0;
            end
        end
        check_eq({tag, "_edges"}, edges, exp_edges);
        check_eq({tag, "_other_idle"}, 32'(other_ok), 1);
    endtask

    initial begin
        int peak;
        checks   = 0;
        failures = 0;
        reset_   = 1'b0;
        bus.soc_a = 1'b0;
        bus.soc_b = 1'b0;
        bus.n_a   = '0;
        bus.n_b   = '0;
        tick();
        tick();
        reset_ = 1'b1;
        check_eq("rst_eoc_a", 32'(bus.eoc_a), 1);
        check_eq("rst_eoc_b", 32'(bus.eoc_b), 1);
        check_eq("rst_k_a", 32'(bus.k_a), 0);
        check_eq("rst_k_b", 32'(bus.k_b), 0);
        check_eq("rst_state", 32'(dut.state_q), 32'(S_IDLE));

        // n_a = 1: done one edge after grant
        bus.n_a = 8'd1; bus.soc_a = 1'b1;
        tick();
        check_eq("n1_eoc_low", 32'(bus.eoc_a), 0);
        await_done(1'b0, 1, 8'd0, "n1", peak);
        check_eq("n1_k_a", 32'(bus.k_a), 0);
        bus.soc_a = 1'b0;
        tick();

        // n_a = 6: 8 steps, 9 edges
        bus.n_a = 8'd6; bus.soc_a = 1'b1;
        tick();
        check_eq("n6_eoc_low", 32'(bus.eoc_a), 0);
        await_done(1'b0, 9, 8'd0, "n6", peak);
        check_eq("n6_k_a", 32'(bus.k_a), 8);
        bus.soc_a = 1'b0;
        tick();

        // n_b = 27: 111 steps, peak 9232
        bus.n_b = 8'd27; bus.soc_b = 1'b1;
        tick();
        check_eq("n27b_eoc_low", 32'(bus.eoc_b), 0);
        await_done(1'b1, 112, 8'd8, "n27b", peak);
        check_eq("n27b_k_b", 32'(bus.k_b), 111);
        check_eq("n27b_peak", peak, 9232);
        bus.soc_b = 1'b0;
        tick();

        // Contested round 1: A first, then B
        bus.n_a = 8'd3; bus.n_b = 8'd7;
        bus.soc_a = 1'b1; bus.soc_b = 1'b1;
        tick();
        check_eq("rr1_a_granted", 32'(bus.eoc_a), 0);
        check_eq("rr1_b_pending", 32'(bus.eoc_b), 1);
        await_done(1'b0, 8, 8'd111, "rr1_a", peak);
        check_eq("rr1_k_a", 32'(bus.k_a), 7);
        bus.soc_a = 1'b0;
        tick();
        check_eq("rr1_b_still_pending", 32'(bus.eoc_b), 1);
        tick();
        check_eq("rr1_b_granted", 32'(bus.eoc_b), 0);
        await_done(1'b1, 17, 8'd7, "rr1_b", peak);
        check_eq("rr1_k_b", 32'(bus.k_b), 16);
        bus.soc_b = 1'b0;
        tick();

        // Contested round 2: B first
        bus.soc_a = 1'b1; bus.soc_b = 1'b1;
        tick();
        check_eq("rr2_b_granted", 32'(bus.eoc_b), 0);
        check_eq("rr2_a_pending", 32'(bus.eoc_a), 1);
        await_done(1'b1, 17, 8'd7, "rr2_b", peak);
        check_eq("rr2_k_b", 32'(bus.k_b), 16);
        bus.soc_b = 1'b0;
        tick();
        tick();
        check_eq("rr2_a_granted", 32'(bus.eoc_a), 0);
        await_done(1'b0, 8, 8'd16, "rr2_a", peak);
        check_eq("rr2_k_a", 32'(bus.k_a), 7);
        bus.soc_a = 1'b0;
        tick();

        // n_a = 0 terminates immediately
        bus.n_a = 8'd0; bus.soc_a = 1'b1;
        tick();
        check_eq("n0_eoc_low", 32'(bus.eoc_a), 0);
        await_done(1'b0, 1, 8'd16, "n0", peak);
        check_eq("n0_k_a", 32'(bus.k_a), 0);
        bus.soc_a = 1'b0;
        tick();

        // Reset during B's run
        bus.n_b = 8'd27; bus.soc_b = 1'b1;
        tick();
        check_eq("rstmid_eoc_low", 32'(bus.eoc_b), 0);
        for (int i = 0; i < 10; i++) tick();
        reset_ = 1'b0;
        tick();
        check_eq("rstmid_eoc_b", 32'(bus.eoc_b), 1);
        check_eq("rstmid_k_b", 32'(bus.k_b), 0);
        check_eq("rstmid_k_a", 32'(bus.k_a), 0);
        check_eq("rstmid_state", 32'(dut.state_q), 32'(S_IDLE));
        reset_ = 1'b1;
        bus.soc_b = 1'b0;
        tick();

        // n_a = 27 with owner dropping soc mid-run; watchdog at 100 if enabled
        bus.n_a = 8'd27; bus.soc_a = 1'b1;
        tick();
        check_eq("wd_eoc_low", 32'(bus.eoc_a), 0);
        bus.soc_a = 1'b0;
`ifdef COLLATZ_WDOG_EN
        await_done(1'b0, 101, 8'd0, "wd", peak);
        check_eq("wd_k_a", 32'(bus.k_a), 255);
`else
        await_done(1'b0, 112, 8'd0, "wd", peak);
        check_eq("wd_k_a", 32'(bus.k_a), 111);
`endif
        tick();
        check_eq("wd_back_idle", 32'(dut.state_q), 32'(S_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
